fp_div_seq: RTL and testbench

//  Iterative IEEE-754 floating-point divider: z = x / b, one restoring quotient bit per cycle.

---
 rtl/fp_div_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq
//   Iterative IEEE-754 divider, z = x / b. It produces one restoring quotient bit
//   per cycle, then normalises and rounds to nearest-even. Operands with a zero
//   exponent (denormals) are treated as signed zero, and results are never denormal.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
//   in_ready is high only in IDLE, and only while flush is low. out_valid is high only
//   in DONE. z and flags hold steady from the moment out_valid rises until the edge
//   where out_ready is seen.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands x, b present
//   in_ready   divider can accept operands
//   x, b       dividend, divisor (W = 1+EXP_W+MAN_W bits)
//   flush      synchronous abort back to IDLE; any pending result is dropped
//   out_valid  z and flags valid
//   out_ready  consumer takes the result
//   z          quotient
//   flags      {invalid, div_by_zero, overflow, underflow, inexact}
//   dbg_state  current FSM state (0 IDLE, 1 DIV, 2 RND, 3 DONE)
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] z,
    output logic [4:0]           flags,
    output logic [1:0]           dbg_state
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int QB  = MAN_W + 3;
    localparam int EW2 = EXP_W + 2;
    localparam int CW  = $clog2(QB + 1);
    localparam int RW  = MAN_W + 2;

    localparam logic [EW2-1:0]        BIAS_E   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] E_MAX    = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] E_ZERO   = '0;
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_sign;
    logic signed [EW2-1:0]   r_e;
    logic [RW-1:0]           r_rem;
    logic [RW-1:0]           r_div;
    logic [QB-1:0]           r_q;
    logic [CW-1:0]           r_cnt;
    logic [W-1:0]            r_z;
    logic [4:0]              r_flags;

    // Operand fields and classification
    logic                    w_xs, w_bs, w_sign;
    logic [EXP_W-1:0]        w_xe, w_be;
    logic [MAN_W-1:0]        w_xm, w_bm;
    logic                    w_x_zero, w_x_inf, w_x_nan, w_x_snan;
    logic                    w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic                    w_special;
    logic                    w_accept;
    logic [EW2-1:0]          w_e_init;
    logic [W-1:0]            w_sp_z;
    logic [4:0]              w_sp_flags;

    assign {w_xs, w_xe, w_xm} = x;
    assign {w_bs, w_be, w_bm} = b;
    assign w_sign = w_xs ^ w_bs;

    assign w_x_zero = (w_xe == '0);
    assign w_x_inf  = (w_xe == EXP_ONES) && (w_xm == '0);
    assign w_x_nan  = (w_xe == EXP_ONES) && (w_xm != '0);
    assign w_x_snan = w_x_nan && !w_xm[MAN_W-1];
    assign w_b_zero = (w_be == '0);
    assign w_b_inf  = (w_be == EXP_ONES) && (w_bm == '0);
    assign w_b_nan  = (w_be == EXP_ONES) && (w_bm != '0);
    assign w_b_snan = w_b_nan && !w_bm[MAN_W-1];

    assign w_special = w_x_zero | w_x_inf | w_x_nan | w_b_zero | w_b_inf | w_b_nan;

    assign in_ready  = (r_state == S_IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;

    // Two extra bits keep the biased difference signed across the full operand range.
    assign w_e_init = {2'b00, w_xe} - {2'b00, w_be} + BIAS_E;

    // Special-operand results, highest priority first.
    always_comb begin
        w_sp_z     = '0;
        w_sp_flags = '0;
        if (w_x_nan || w_b_nan) begin
            w_sp_z     = QNAN;
            w_sp_flags = {w_x_snan | w_b_snan, 4'b0000};
        end else if ((w_x_zero && w_b_zero) || (w_x_inf && w_b_inf)) begin
            w_sp_z     = QNAN;
            w_sp_flags = 5'b10000;
        end else if (w_x_inf) begin
            w_sp_z     = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_sp_z     = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_sp_flags = 5'b01000;
        end else begin
            w_sp_z     = {w_sign, {(W-1){1'b0}}};
        end
    end

    // Restoring step
    logic w_ge;
    assign w_ge = (r_rem >= r_div);

    // Normalise and round. After normalisation the hidden bit sits above w_qn, the
    // fraction is w_qn[QB-2:2], the guard is w_qn[1] and w_qn[0] is the dropped bit.
    logic [QB-2:0]           w_qn;
    logic signed [EW2-1:0]   w_en;
    logic                    w_guard, w_sticky, w_rup, w_inexact;
    logic [MAN_W:0]          w_msum;
    logic signed [EW2-1:0]   w_er;
    logic [W-1:0]            w_rnd_z;
    logic [4:0]              w_rnd_flags;

    assign w_qn      = r_q[QB-1] ? r_q[QB-2:0] : {r_q[QB-3:0], 1'b0};
    assign w_en      = r_q[QB-1] ? r_e : r_e - EW2'(1);
    assign w_guard   = w_qn[1];
    assign w_sticky  = w_qn[0] | (r_rem != '0);
    assign w_rup     = w_guard & (w_sticky | w_qn[2]);
    assign w_msum    = {1'b0, w_qn[QB-2:2]} + {{MAN_W{1'b0}}, w_rup};
    // A carry out of the fraction leaves it all zeros and bumps the exponent.
    assign w_er      = w_en + {{(EW2-1){1'b0}}, w_msum[MAN_W]};
    assign w_inexact = w_guard | w_sticky;

    always_comb begin
        w_rnd_z     = '0;
        w_rnd_flags = '0;
        if (w_er >= E_MAX) begin
            w_rnd_z     = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_rnd_flags = 5'b00101;
        end else if (w_er <= E_ZERO) begin
            w_rnd_z     = {r_sign, {(W-1){1'b0}}};
            w_rnd_flags = 5'b00011;
        end else begin
            w_rnd_z     = {r_sign, w_er[EXP_W-1:0], w_msum[MAN_W-1:0]};
            w_rnd_flags = {4'b0000, w_inexact};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_DIV;
            S_DIV:   if (r_cnt == CW'(1)) w_state_nxt = S_RND;
            S_RND:   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_e     <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_z     <= '0;
            r_flags <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_z     <= w_sp_z;
                            r_flags <= w_sp_flags;
                        end else begin
                            r_e   <= w_e_init;
                            r_rem <= {1'b0, 1'b1, w_xm};
                            r_div <= {1'b0, 1'b1, w_bm};
                            r_q   <= '0;
                            r_cnt <= CW'(QB);
                        end
                    end
                end
                S_DIV: begin
                    // rem stays below 2*div, so the shifted value always fits RW bits.
                    if (w_ge) begin
                        r_q   <= {r_q[QB-2:0], 1'b1};
                        r_rem <= (r_rem - r_div) << 1;
                    end else begin
                        r_q   <= {r_q[QB-2:0], 1'b0};
                        r_rem <= r_rem << 1;
                    end
                    r_cnt <= r_cnt - CW'(1);
                end
                S_RND: begin
                    r_z     <= w_rnd_z;
                    r_flags <= w_rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign z         = r_z;
    assign flags     = r_flags;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq (EXP_W=8, MAN_W=23). Expected values are hand-computed.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [4:0]  flags;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] F_6   = 32'h40C00000;
    localparam logic [31:0] F_2   = 32'h40000000;
    localparam logic [31:0] F_1   = 32'h3F800000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_3RD = 32'h3EAAAAAB;
    localparam logic [31:0] QNAN  = 32'h7FC00000;
    localparam logic [31:0] PINF  = 32'h7F800000;
    localparam logic [31:0] NINF  = 32'hFF800000;

    always #5 clk = ~clk;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    // Driver: present operands in the current cycle, count cycles until out_valid,
    // capture the result and complete a one-cycle output handshake.
    task automatic do_op(input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rz, output logic [4:0] rf, output int lat);
        x = a;
        b = d;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (out_valid !== 1'b1 && lat < 200);
        rz = z;
        rf = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL reset_z got %h exp 00000000", z); end
        checks++; if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", flags); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_normal;
        logic [31:0] rz; logic [4:0] rf; int lat;
        logic [31:0] vx[4], vb[4], ez[4];
        logic [4:0]  ef[4];
        vx[0] = F_6;          vb[0] = F_2;          ez[0] = F_3;          ef[0] = 5'b00000;
        vx[1] = F_1;          vb[1] = F_3;          ez[1] = F_3RD;        ef[1] = 5'b00001;
        vx[2] = F_1;          vb[2] = 32'hC0800000; ez[2] = 32'hBE800000; ef[2] = 5'b00000;
        vx[3] = 32'h7F7FFFFF; vb[3] = 32'h3F000000; ez[3] = PINF;         ef[3] = 5'b00101;
        for (int i = 0; i < 4; i++) begin
            do_op(vx[i], vb[i], rz, rf, lat);
            checks++; if (rz !== ez[i]) begin errors++; $display("FAIL normal[%0d]_z got %h exp %h", i, rz, ez[i]); end
            checks++; if (rf !== ef[i]) begin errors++; $display("FAIL normal[%0d]_flags got %b exp %b", i, rf, ef[i]); end
            checks++; if (lat !== 28) begin errors++; $display("FAIL normal[%0d]_latency got %0d exp 28", i, lat); end
        end
        // Underflow to zero
        do_op(32'h00800000, F_2, rz, rf, lat);
        checks++; if (rz !== 32'h0) begin errors++; $display("FAIL underflow_z got %h exp 00000000", rz); end
        checks++; if (rf !== 5'b00011) begin errors++; $display("FAIL underflow_flags got %b exp 00011", rf); end
    endtask

    task automatic test_specials;
        logic [31:0] rz; logic [4:0] rf; int lat;
        logic [31:0] vx[9], vb[9], ez[9];
        logic [4:0]  ef[9];
        vx[0] = F_1;          vb[0] = 32'h00000000; ez[0] = PINF;         ef[0] = 5'b01000;
        vx[1] = 32'h00000000; vb[1] = 32'h00000000; ez[1] = QNAN;         ef[1] = 5'b10000;
        vx[2] = NINF;         vb[2] = F_2;          ez[2] = NINF;         ef[2] = 5'b00000;
        vx[3] = 32'h7F800001; vb[3] = F_1;          ez[3] = QNAN;         ef[3] = 5'b10000;
        vx[4] = F_1;          vb[4] = 32'hFFC00000; ez[4] = QNAN;         ef[4] = 5'b00000;
        vx[5] = PINF;         vb[5] = NINF;         ez[5] = QNAN;         ef[5] = 5'b10000;
        vx[6] = 32'h80000000; vb[6] = PINF;         ez[6] = 32'h80000000; ef[6] = 5'b00000;
        vx[7] = 32'h00000001; vb[7] = 32'hBF800000; ez[7] = 32'h80000000; ef[7] = 5'b00000;
        vx[8] = PINF;         vb[8] = 32'h00000000; ez[8] = PINF;         ef[8] = 5'b00000;
        for (int i = 0; i < 9; i++) begin
            do_op(vx[i], vb[i], rz, rf, lat);
            checks++; if (rz !== ez[i]) begin errors++; $display("FAIL special[%0d]_z got %h exp %h", i, rz, ez[i]); end
            checks++; if (rf !== ef[i]) begin errors++; $display("FAIL special[%0d]_flags got %b exp %b", i, rf, ef[i]); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL special[%0d]_latency got %0d exp 1", i, lat); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rz; logic [4:0] rf; int lat;
        int n;
        x = F_6; b = F_2; in_valid = 1'b1; n = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
        end while (out_valid !== 1'b1 && n < 200);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_wait out_valid got %b exp 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (z !== F_3 || flags !== 5'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] z=%h flags=%b out_valid=%b in_ready=%b exp z=%h flags=00000 out_valid=1 in_ready=0",
                         i, z, flags, out_valid, in_ready, F_3);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
        do_op(F_1, F_3, rz, rf, lat);
        checks++; if (rz !== F_3RD || rf !== 5'b00001 || lat !== 28) begin
            errors++; $display("FAIL b2b_first z=%h flags=%b lat=%0d exp z=%h flags=00001 lat=28", rz, rf, lat, F_3RD);
        end
        do_op(NINF, F_2, rz, rf, lat);
        checks++; if (rz !== NINF || rf !== 5'b0 || lat !== 1) begin
            errors++; $display("FAIL b2b_second z=%h flags=%b lat=%0d exp z=%h flags=00000 lat=1", rz, rf, lat, NINF);
        end
    endtask

    task automatic test_abort;
        logic [31:0] rz; logic [4:0] rf; int lat;
        int seen;
        // Reset in the middle of a division; z holds a nonzero result beforehand.
        x = F_6; b = F_2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL abort_rst_pre_state got %0d exp 1", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_rst_out_valid got %b exp 0", out_valid); end
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL abort_rst_z got %h exp 00000000", z); end
        checks++; if (flags !== 5'b0) begin errors++; $display("FAIL abort_rst_flags got %b exp 00000", flags); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_rst_state got %0d exp 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_rst_in_ready got %b exp 1", in_ready); end

        // Flush in the middle of a division.
        x = F_1; b = F_3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL flush_state got %0d exp 0", dbg_state); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end

        // in_valid together with flush is not accepted.
        flush = 1'b1; in_valid = 1'b1; x = F_6; b = F_2;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL flush_accept_state got %0d exp 0", dbg_state); end

        // No result may appear from the dropped operations.
        seen = 0;
        for (int i = 0; i < 32; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result out_valid cycles got %0d exp 0", seen); end

        do_op(F_6, F_2, rz, rf, lat);
        checks++; if (rz !== F_3 || rf !== 5'b0 || lat !== 28) begin
            errors++; $display("FAIL after_abort z=%h flags=%b lat=%0d exp z=%h flags=00000 lat=28", rz, rf, lat, F_3);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        x = '0; b = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_normal;
        test_specials;
        test_backpressure;
        test_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
